mux_nto1_cfg_ctx: RTL

//  Parametrised N-input, SIZE-bit CGRA routing mux. Select values come from an internal serial config chain, not a port.
//  The chain holds CONTEXTS select words; the ctx input picks the live one each cycle.
//  Per-input valids are forwarded; an optional output register is provided; illegal selects are flagged.

---
 rtl/mux_nto1_cfg_ctx_pkg.sv | 20 ++
 rtl/mux_nto1_cfg_ctx_if.sv | 30 +++
 rtl/mux_nto1_cfg_ctx_chain.sv | 23 ++
 rtl/mux_nto1_cfg_ctx.sv | 58 +++++
 4 files changed

// File: rtl/mux_nto1_cfg_ctx_pkg.sv
// cgra_mux_pkg: width helpers and chain-order constant shared by the mux and its config cells
// Exports clog2, sel_w, ctx_w, cfg_bits and CGRA_CFG_SHIFT_LSB_OUT.
package cgra_mux_pkg;
  // Chains shift toward bit 0; bit 0 leaves the cell and feeds the next one.
  localparam bit CGRA_CFG_SHIFT_LSB_OUT = 1'b1;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int sel_w(input int n);
    return clog2(n);
  endfunction
  function automatic int ctx_w(input int c);
    return c > 1 ? clog2(c) : 1;
  endfunction
  function automatic int cfg_bits(input int n, input int c);
    return c * sel_w(n);
  endfunction
endpackage

// File: rtl/mux_nto1_cfg_ctx_if.sv
// mux_nto1_cfg_ctx_if: data, valid, context and config-chain bus of the routing mux
// Inputs: in_flat, in_valid, ctx, config_enable, config_in.
// Outputs: config_out, out, out_valid, sel_error.
// master drives the inputs, slave is the mux.
interface mux_nto1_cfg_ctx_if
  import cgra_mux_pkg::*;
#(
  parameter int SIZE       = 32,
  parameter int NUM_INPUTS = 10,
  parameter int CONTEXTS   = 2
) ();
  localparam int CTX_W = ctx_w(CONTEXTS);
  logic [NUM_INPUTS*SIZE-1:0] in_flat;
  logic [NUM_INPUTS-1:0]      in_valid;
  logic [CTX_W-1:0]           ctx;
  logic                       config_enable;
  logic                       config_in;
  logic                       config_out;
  logic [SIZE-1:0]            out;
  logic                       out_valid;
  logic                       sel_error;
  modport master (
    output in_flat, in_valid, ctx, config_enable, config_in,
    input  config_out, out, out_valid, sel_error
  );
  modport slave (
    input  in_flat, in_valid, ctx, config_enable, config_in,
    output config_out, out, out_valid, sel_error
  );
endinterface

// File: rtl/mux_nto1_cfg_ctx_chain.sv
// config_shift_chain: serial config register, shifts toward bit 0 while enabled
// Ports: clk, rst_n (async active-low), enable, in (serial in), out (= data[0]), data (parallel contents).
module config_shift_chain #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             in,
  output logic             out,
  output logic [WIDTH-1:0] data
);
  if (WIDTH > 1) begin : g_wide
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) data <= '0;
      else if (enable) data <= {in, data[WIDTH-1:1]};
  end else begin : g_bit
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) data <= '0;
      else if (enable) data <= in;
  end
  assign out = data[0];
endmodule

// File: rtl/mux_nto1_cfg_ctx.sv
// mux_nto1_cfg_ctx: N:1 CGRA routing mux with per-context selects held in a serial config chain
// Ports: CGRA_Clock, CGRA_Reset_n (async active-low), bus (slave side of mux_nto1_cfg_ctx_if).
// REGISTERED=1 gives a one-cycle output register that only loads on valid; 0 is purely combinational.
module mux_nto1_cfg_ctx
  import cgra_mux_pkg::*;
#(
  parameter int SIZE       = 32,
  parameter int NUM_INPUTS = 10,
  parameter int CONTEXTS   = 2,
  parameter int REGISTERED = 1
) (
  input logic CGRA_Clock,
  input logic CGRA_Reset_n,
  mux_nto1_cfg_ctx_if.slave bus
);
  localparam int SEL_W    = sel_w(NUM_INPUTS);
  localparam int CTX_W    = ctx_w(CONTEXTS);
  localparam int CFG_BITS = cfg_bits(NUM_INPUTS, CONTEXTS);
  // Chain padded to every ctx encoding so out-of-range contexts read zeros rather than past the end.
  localparam int PAD_W    = (1 << CTX_W) * SEL_W;
  logic [CFG_BITS-1:0] chain;
  logic [PAD_W-1:0]    padded;
  logic [SEL_W-1:0]    sel;
  logic [SIZE-1:0]     data;
  logic                legal;
  logic                v;
  config_shift_chain #(.WIDTH(CFG_BITS)) u_chain (
    .clk    (CGRA_Clock),
    .rst_n  (CGRA_Reset_n),
    .enable (bus.config_enable),
    .in     (bus.config_in),
    .out    (bus.config_out),
    .data   (chain)
  );
  assign padded = PAD_W'(chain);
  assign sel    = padded[bus.ctx*SEL_W +: SEL_W];
  assign legal  = int'(bus.ctx) < CONTEXTS && int'(sel) < NUM_INPUTS;
  assign data   = legal ? bus.in_flat[sel*SIZE +: SIZE] : '0;
  assign v      = legal && bus.in_valid[sel] && !bus.config_enable;
  // Sticky until a reload starts; reload cycles never flag.
  always_ff @(posedge CGRA_Clock or negedge CGRA_Reset_n)
    if (!CGRA_Reset_n) bus.sel_error <= 1'b0;
    else if (bus.config_enable) bus.sel_error <= 1'b0;
    else if (!legal) bus.sel_error <= 1'b1;
  if (REGISTERED != 0) begin : g_reg
    always_ff @(posedge CGRA_Clock or negedge CGRA_Reset_n)
      if (!CGRA_Reset_n) begin
        bus.out       <= '0;
        bus.out_valid <= 1'b0;
      end else begin
        bus.out_valid <= v;
        if (v) bus.out <= data;
      end
  end else begin : g_comb
    assign bus.out       = data;
    assign bus.out_valid = v;
  end
endmodule
